booth_digit_decoder: RTL and testbench
======================================

BOOTH_DIGIT_DECODER -- requirements
Module: booth_digit_decoder

Interface
REQ-001 Parameter WIDTH, default 8, multiplicand width in bits (signed two's complement).
REQ-002 Parameter NDIG, default 4, number of radix-4 Booth digits per operation.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port start  input  1  begin operation; sampled in IDLE only.
REQ-006 Port mcand  input  WIDTH  signed multiplicand; captured on accepted start.
REQ-007 Port dig_valid  input  1  a Booth digit is present on c0/c1/c2.
REQ-008 Port dig_ready  output  1  decoder accepts a digit this cycle.
REQ-009 Port c0 / c1 / c2  input  1 each  Booth digit code: c0 = select 1x, c1 = select 2x, c2 = negate.
REQ-010 Port busy  output  1  high in RUN.
REQ-011 Port done  output  1  one-cycle pulse when product is final.
REQ-012 Port product  output  WIDTH+2*NDIG  signed accumulated product.
REQ-013 Port err  output  1  sticky illegal-digit flag.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL capture mcand, clear product, err and the digit counter, and enter RUN on the next cycle.
REQ-016 dig_ready SHALL equal 1 exactly when the state is RUN; a digit is accepted when dig_valid & dig_ready.
REQ-017 Digit value decode SHALL be {c2,c1,c0}: 000 and 100 -> 0, 001 -> +1, 010 -> +2, 101 -> -1, 110 -> -2; 011 and 111 are illegal.
REQ-018 For the k-th accepted digit (k = 0 first, LSB first), product SHALL update to product + (value * sign-extended mcand) << 2k, with wrap modulo 2^(WIDTH+2*NDIG).
REQ-019 No accumulation SHALL occur in a RUN cycle with dig_valid=0; arbitrary gaps between digits are legal.
REQ-020 After the NDIG-th digit is accepted, the FSM SHALL enter DONE on the next cycle, assert done for exactly that cycle, then return to IDLE.
REQ-021 product SHALL hold its final value from DONE until the next accepted start or reset.
REQ-022 start asserted in RUN or DONE SHALL be ignored.
REQ-023 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.

Reset
REQ-024 rst=1 SHALL force state IDLE, product=0, done=0, busy=0, err=0, dig_ready=0, digit counter=0 and the captured multiplicand=0 on the next edge, including mid-operation.
REQ-025 rst SHALL take priority over start and digit acceptance in the same cycle.

Configuration
REQ-026 With macro BOOTH_DEC_ERR_CHK_EN defined, an accepted illegal digit SHALL set err (sticky until the next accepted start or reset) and contribute 0 to product, while still counting as a digit.
REQ-027 Without BOOTH_DEC_ERR_CHK_EN, err SHALL be tied to 0, and codes 011 and 111 SHALL decode as +2 and -2 respectively (c1 priority).

Structure
REQ-028 A shared package booth_pkg SHALL hold the FSM state enum, the digit-code constants and the product-width function WIDTH+2*NDIG.
REQ-029 A combinational sub-module booth_digit_term SHALL map {c2,c1,c0} and the multiplicand to the signed term (0, +/-1x, +/-2x) and to the illegal flag.

Verification (WIDTH=8, NDIG=4)
REQ-030 mcand=5, digits +1,+1,0,0 back-to-back -> done pulses 1 cycle after the 4th digit, product=16'd25.
REQ-031 mcand=8'hFD (-3), digits -2,+1,0,0 -> product=16'hFFFA (-6).
REQ-032 mcand=127, digits +2,+2,+2,+2 with dig_valid low 2 cycles between digits -> product=16'h5456 (21590), dig_ready=1 throughout RUN.
REQ-033 With BOOTH_DEC_ERR_CHK_EN: mcand=5, digits 011,+1,0,0 -> err=1, product=16'd20; after a new start, err=0.
REQ-034 rst pulsed after 2 digits accepted -> next cycle IDLE with product=0 and busy=0; a following full operation with mcand=5, digits +1,+1,0,0 gives product=16'd25.
REQ-035 start held high during RUN -> ignored; mcand is not recaptured and the digit count is unaffected.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth digit decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Digit codes are {c2,c1,c0}: c2 negates, c1 selects 2x, c0 selects 1x.
  localparam logic [2:0] DIG_Z  = 3'b000;
  localparam logic [2:0] DIG_P1 = 3'b001;
  localparam logic [2:0] DIG_P2 = 3'b010;
  localparam logic [2:0] DIG_IP = 3'b011;
  localparam logic [2:0] DIG_NZ = 3'b100;
  localparam logic [2:0] DIG_M1 = 3'b101;
  localparam logic [2:0] DIG_M2 = 3'b110;
  localparam logic [2:0] DIG_IM = 3'b111;

  function automatic int prod_w(input int width, input int ndig);
    return width + 2 * ndig;
  endfunction

endpackage

// File: rtl/booth_digit_term.sv
// Maps one Booth digit code and the multiplicand to a signed partial term.
// BOOTH_DEC_ERR_CHK_EN: codes 011/111 yield 0 instead of +/-2x.
module booth_digit_term
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       code,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH+1:0] term,
  output logic             illegal
);

  logic signed [WIDTH+1:0] m1, m2;

  // Two extra bits cover -2 * most-negative multiplicand.
  assign m1 = {{2{mcand[WIDTH-1]}}, mcand};
  assign m2 = {mcand[WIDTH-1], mcand, 1'b0};

  assign illegal = (code == DIG_IP) || (code == DIG_IM);

  always_comb begin
    term = '0;
    case (code)
      DIG_P1:  term = m1;
      DIG_P2:  term = m2;
      DIG_M1:  term = -m1;
      DIG_M2:  term = -m2;
`ifndef BOOTH_DEC_ERR_CHK_EN
      DIG_IP:  term = m2;
      DIG_IM:  term = -m2;
`endif
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/booth_digit_decoder.sv
// Serial radix-4 Booth accumulator: one digit per accepted beat, LSB digit first.
// BOOTH_DEC_ERR_CHK_EN enables the sticky illegal-digit flag on err.
module booth_digit_decoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NDIG  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          mcand,
  input  logic                      dig_valid,
  output logic                      dig_ready,
  input  logic                      c0,
  input  logic                      c1,
  input  logic                      c2,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH+2*NDIG-1:0]   product,
  output logic                      err
);

  localparam int PW = prod_w(WIDTH, NDIG);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  mc_q;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     prod_q;
  logic [WIDTH+1:0]  term;
  logic              ill;
  logic              acc, last, start_ok;
  logic signed [PW-1:0] term_ext;
  logic [PW-1:0]     addend;

  booth_digit_term #(.WIDTH(WIDTH)) u_term (
    .code    ({c2, c1, c0}),
    .mcand   (mc_q),
    .term    (term),
    .illegal (ill)
  );

  assign acc      = dig_valid & dig_ready;
  assign last     = (cnt == CW'(NDIG - 1));
  assign start_ok = (state == S_IDLE) && start;
  assign term_ext = PW'($signed(term));
  // Digit k carries weight 4^k.
  assign addend   = term_ext << {cnt, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start)        state_nx = S_RUN;
      S_RUN:   if (acc && last)  state_nx = S_DONE;
      S_DONE:                    state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    dig_ready = (state == S_RUN);
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_q   <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else if (start_ok) begin
      mc_q   <= mcand;
      cnt    <= '0;
      prod_q <= '0;
    end else if (acc) begin
      cnt    <= cnt + 1'b1;
      prod_q <= prod_q + addend;
    end
  end

  assign product = prod_q;

`ifdef BOOTH_DEC_ERR_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                err_q <= 1'b0;
    else if (start_ok)      err_q <= 1'b0;
    else if (acc && ill)    err_q <= 1'b1;
  end
  assign err = err_q;
`else
  logic unused_ill;
  assign unused_ill = ill;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_digit_decoder.sv
// Scoreboard bench for booth_digit_decoder: directed + random operations vs arithmetic model.
module tb_booth_digit_decoder;

  localparam int WIDTH = 8;
  localparam int NDIG  = 4;
  localparam int PW    = WIDTH + 2 * NDIG;

  logic             clk = 1'b0;
  logic             rst, start, dig_valid, c0, c1, c2;
  logic [WIDTH-1:0] mcand;
  logic             dig_ready, busy, done, err;
  logic [PW-1:0]    product;

  typedef struct {
    logic [PW-1:0] prod;
    logic          err;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  booth_digit_decoder #(.WIDTH(WIDTH), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mcand     (mcand),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: product = mcand * sum(value_k * 4^k), modulo 2^PW.
  function automatic exp_t model(input logic [WIDTH-1:0] m, input logic [NDIG-1:0][2:0] codes);
    exp_t   e;
    longint w = 0;
    int     v;
    e.err = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      case (codes[k])
        3'b001:  v = 1;
        3'b010:  v = 2;
        3'b101:  v = -1;
        3'b110:  v = -2;
`ifdef BOOTH_DEC_ERR_CHK_EN
        3'b011, 3'b111: begin v = 0; e.err = 1'b1; end
`else
        3'b011:  v = 2;
        3'b111:  v = -2;
`endif
        default: v = 0;
      endcase
      w += longint'(v) * (longint'(1) << (2 * k));
    end
    e.prod = PW'(w * longint'($signed(m)));
    return e;
  endfunction

  // Monitor: every done pulse consumes one expectation.
  initial begin
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_pulse_width", {31'b0, prev}, 32'd0);
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("product", {16'b0, product}, {16'b0, e.prod});
          chk("err", {31'b0, err}, {31'b0, e.err});
        end
      end
      prev = done;
    end
  end

  task automatic run_op(input logic [WIDTH-1:0] m, input logic [NDIG-1:0][2:0] codes,
                        input int gmin, input int gmax, input bit hold_start, input int abort_after);
    exp_t e;
    int   gaps;
    e = model(m, codes);
    @(posedge clk); #1;
    start = 1'b1; mcand = m;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    mcand = ~m;
    chk("busy_in_run", {31'b0, busy}, 32'd1);
    chk("cleared_product", {16'b0, product}, 32'd0);
    chk("cleared_err", {31'b0, err}, 32'd0);
    for (int k = 0; k < NDIG; k++) begin
      if (k == abort_after) begin
        rst = 1'b1; dig_valid = 1'b1; {c2, c1, c0} = 3'b010;
        @(posedge clk); #1;
        rst = 1'b0; dig_valid = 1'b0; start = 1'b0;
        chk("rst_product", {16'b0, product}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ready", {31'b0, dig_ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        return;
      end
      gaps = gmin + int'($urandom_range(gmax - gmin, 0));
      repeat (gaps) begin
        dig_valid = 1'b0; {c2, c1, c0} = 3'($urandom);
        @(posedge clk); #1;
        chk("ready_in_gap", {31'b0, dig_ready}, 32'd1);
      end
      if (k == NDIG - 1) begin
        start = 1'b0;
        sbq.push_back(e);
      end
      dig_valid = 1'b1; {c2, c1, c0} = codes[k];
      chk("dig_ready", {31'b0, dig_ready}, 32'd1);
      @(posedge clk); #1;
      dig_valid = 1'b0;
    end
    chk("done_after_last", {31'b0, done}, 32'd1);
    chk("busy_in_done", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("idle_done_low", {31'b0, done}, 32'd0);
    chk("idle_ready_low", {31'b0, dig_ready}, 32'd0);
    @(posedge clk); #1;
    chk("product_held", {16'b0, product}, {16'b0, e.prod});
  endtask

  initial begin
    logic [NDIG-1:0][2:0] codes;
    rst = 1'b1; start = 1'b1; mcand = 8'hA5; dig_valid = 1'b1; {c2, c1, c0} = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", {16'b0, product}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_ready", {31'b0, dig_ready}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    rst = 1'b0; start = 1'b0; dig_valid = 1'b0;

    run_op(8'd5,   {3'b000, 3'b000, 3'b001, 3'b001}, 0, 0, 1'b0, -1);
    run_op(8'hFD,  {3'b000, 3'b000, 3'b001, 3'b110}, 0, 0, 1'b0, -1);
    run_op(8'd127, {3'b010, 3'b010, 3'b010, 3'b010}, 2, 2, 1'b0, -1);
    run_op(8'd5,   {3'b000, 3'b000, 3'b001, 3'b011}, 0, 0, 1'b0, -1);
    run_op(8'd9,   {3'b001, 3'b000, 3'b101, 3'b100}, 0, 1, 1'b0, -1);
    run_op(8'd7,   {3'b001, 3'b001, 3'b001, 3'b001}, 0, 0, 1'b0, 2);
    run_op(8'd5,   {3'b000, 3'b000, 3'b001, 3'b001}, 0, 0, 1'b0, -1);
    run_op(8'h80,  {3'b110, 3'b111, 3'b010, 3'b110}, 0, 1, 1'b1, -1);
    run_op(8'd33,  {3'b101, 3'b001, 3'b110, 3'b010}, 1, 3, 1'b1, -1);

    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NDIG; k++) codes[k] = 3'($urandom);
      run_op(8'($urandom), codes, 0, 3, 1'($urandom), -1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
